// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and width helpers for the synchronous FIFO control slice.
//   OB_DEPTH      : depth of the output register queue behind the memory
//   OB_CNT_WIDTH  : width of the output queue occupancy counter (0..OB_DEPTH)
//   ptr_width()   : pointer width for a given address width (one wrap bit)
//   count_width() : total occupancy width (memory + in-flight + output queue)
package fifo_pkg;

  localparam int OB_DEPTH     = 2;
  localparam int OB_CNT_WIDTH = 2;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf
// Two-entry in-order register queue that sits after the 1-cycle-latency
// memory read port. entry0 is always the head.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   push       : write push_data at the tail this edge
//   push_data  : word to enqueue
//   pop        : drop the head this edge (only while cnt != 0)
//   head_data  : current head word (held stable until popped)
//   cnt        : number of valid entries, 0..OB_DEPTH
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [OB_CNT_WIDTH-1:0] cnt
);

  localparam logic [OB_CNT_WIDTH-1:0] FULL_CNT = OB_CNT_WIDTH'(OB_DEPTH);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;

  assign head_data = entry0;

  // Push and pop in the same cycle keep the count; when the queue is full the
  // tail slides into the head and the new word takes the tail. The issue logic
  // upstream never pushes into a full queue without a simultaneous pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) entry0 <= push_data;
          else           entry1 <= push_data;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 1'b1;
        end
        2'b11: begin
          if (cnt == FULL_CNT) begin
            entry0 <= entry1;
            entry1 <= push_data;
          end else begin
            entry0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
// Control and output stage of a synchronous FIFO built around an external
// dual-port memory with 1-cycle read latency. Words are accepted on a
// valid/ready write side, written straight into memory, read back ahead of
// demand and staged in a 2-entry output queue that gives a first-word-
// fall-through valid/ready read side at one word per cycle.
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data    : write side, transfer on s_valid && s_ready
//   m_valid/m_ready/m_data    : read side (FWFT), pop on m_valid && m_ready
//   mem_write_en/addr/data    : memory write port
//   mem_read_en/addr          : memory read request
//   mem_read_data             : memory read data, valid the cycle after the request
//   count                     : words held (memory + in-flight read + output queue)
//   full                      : memory full (same as !s_ready)
//   empty                     : count == 0
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [PW-1:0] MEM_DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [OB_CNT_WIDTH:0] OB_LIMIT = (OB_CNT_WIDTH+1)'(OB_DEPTH);

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           mem_cnt;
  logic                    rd_pend;
  logic                    mem_full;
  logic                    mem_empty;
  logic                    wr_accept;
  logic                    pop;
  logic                    issue;
  logic [OB_CNT_WIDTH-1:0] ob_cnt;
  logic [OB_CNT_WIDTH:0]   ob_claim;

  // The extra MSB on each pointer distinguishes full from empty when the
  // address bits are equal; plain modulo subtraction handles wrap-around.
  assign mem_cnt   = wr_ptr - rd_ptr;
  assign mem_full  = (mem_cnt == MEM_DEPTH_P);
  assign mem_empty = (mem_cnt == '0);

  assign s_ready   = !mem_full;
  assign full      = mem_full;
  assign wr_accept = s_valid && s_ready;

  assign mem_write_en   = wr_accept;
  assign mem_write_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_write_data = s_data;

  assign pop = m_valid && m_ready;

  // Slots of the output queue that will be occupied after this edge, counting
  // the read already in flight. A new read is only issued if its word is
  // guaranteed a slot when it lands next cycle.
  assign ob_claim = {1'b0, ob_cnt}
                  + {{OB_CNT_WIDTH{1'b0}}, rd_pend}
                  - {{OB_CNT_WIDTH{1'b0}}, pop};
  assign issue    = !mem_empty && (ob_claim < OB_LIMIT);

  assign mem_read_en   = issue;
  assign mem_read_addr = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (issue)     rd_ptr <= rd_ptr + 1'b1;
      rd_pend <= issue;
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rstn     (rstn),
    .push     (rd_pend),
    .push_data(mem_read_data),
    .pop      (pop),
    .head_data(m_data),
    .cnt      (ob_cnt)
  );

  assign m_valid = (ob_cnt != '0);

  assign count = CW'(mem_cnt) + CW'(rd_pend) + CW'(ob_cnt);
  assign empty = (count == '0);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl
// Directed self-checking bench for sync_fifo_ctrl with a 4-word memory
// (ADDR_WIDTH=2, total capacity 6). A behavioural 1-cycle-latency memory is
// attached to the memory ports. Inputs change 1 time unit after the rising
// edge; outputs are checked before the next edge, and a negedge scoreboard
// tracks every accepted word against every popped word.
module tb_sync_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_en;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data;
  logic [AW+1:0] count;
  logic          full;
  logic          empty;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sbq[$];
  logic [DW-1:0] sb_exp;
  logic [DW-1:0] mem_model [0:(1<<AW)-1];

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .mem_write_en  (mem_write_en),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_en   (mem_read_en),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_write_en) mem_model[mem_write_addr] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= mem_model[mem_read_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Ordering scoreboard: words leave in the order they were accepted.
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
    end else begin
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_unexpected_pop", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          sb_exp = sbq.pop_front();
          checkOutput("sb_order", {24'd0, m_data}, {24'd0, sb_exp});
        end
      end
      if (s_valid && s_ready) sbq.push_back(s_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sv, input logic [DW-1:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_s_ready"}, {31'd0, s_ready}, 1);
    checkOutput({pfx, "_m_valid"}, {31'd0, m_valid}, 0);
    checkOutput({pfx, "_m_data"}, {24'd0, m_data}, 0);
    checkOutput({pfx, "_mem_write_en"}, {31'd0, mem_write_en}, 0);
    checkOutput({pfx, "_mem_read_en"}, {31'd0, mem_read_en}, 0);
    checkOutput({pfx, "_wr_addr"}, {30'd0, mem_write_addr}, 0);
    checkOutput({pfx, "_rd_addr"}, {30'd0, mem_read_addr}, 0);
    checkOutput({pfx, "_count"}, {28'd0, count}, 0);
    checkOutput({pfx, "_full"}, {31'd0, full}, 0);
    checkOutput({pfx, "_empty"}, {31'd0, empty}, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int guard;
    logic          held;
    logic [DW-1:0] prev;

    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // Reset values
    #12;
    checkResetState("rst");
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single word latency: accept at E0, visible after E2
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("t1_wr_en", {31'd0, mem_write_en}, 1);
    checkOutput("t1_wr_addr", {30'd0, mem_write_addr}, 0);
    checkOutput("t1_wr_data", {24'd0, mem_write_data}, 32'h11);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_c1_count", {28'd0, count}, 1);
    checkOutput("t1_c1_empty", {31'd0, empty}, 0);
    checkOutput("t1_c1_m_valid", {31'd0, m_valid}, 0);
    checkOutput("t1_c1_rd_en", {31'd0, mem_read_en}, 1);
    checkOutput("t1_c1_rd_addr", {30'd0, mem_read_addr}, 0);
    tick();
    checkOutput("t1_c2_count", {28'd0, count}, 1);
    checkOutput("t1_c2_m_valid", {31'd0, m_valid}, 0);
    checkOutput("t1_c2_rd_en", {31'd0, mem_read_en}, 0);
    tick();
    checkOutput("t1_c3_m_valid", {31'd0, m_valid}, 1);
    checkOutput("t1_c3_m_data", {24'd0, m_data}, 32'h11);
    checkOutput("t1_c3_count", {28'd0, count}, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_pop_empty", {31'd0, empty}, 1);
    checkOutput("t1_pop_count", {28'd0, count}, 0);
    checkOutput("t1_pop_m_valid", {31'd0, m_valid}, 0);

    // Fill to capacity 6 with the consumer stalled
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("fill_ready", {31'd0, s_ready}, 1);
      tick();
    end
    applyStimulus(1'b1, 8'h07, 1'b0);
    checkOutput("fill_full", {31'd0, full}, 1);
    checkOutput("fill_s_ready", {31'd0, s_ready}, 0);
    checkOutput("fill_count", {28'd0, count}, 6);
    checkOutput("fill_no_write", {31'd0, mem_write_en}, 0);
    tick();
    tick();
    checkOutput("fill_hold_full", {31'd0, full}, 1);
    checkOutput("fill_hold_count", {28'd0, count}, 6);
    checkOutput("fill_head", {24'd0, m_data}, 1);
    applyStimulus(1'b1, 8'h07, 1'b1);
    checkOutput("fill_pop_rd_en", {31'd0, mem_read_en}, 1);
    checkOutput("fill_pop_s_ready", {31'd0, s_ready}, 0);
    tick();
    applyStimulus(1'b1, 8'h07, 1'b0);
    checkOutput("fill_7_ready", {31'd0, s_ready}, 1);
    checkOutput("fill_7_wr_en", {31'd0, mem_write_en}, 1);
    checkOutput("fill_7_wr_data", {24'd0, mem_write_data}, 7);
    checkOutput("fill_7_count", {28'd0, count}, 5);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fill_refull_count", {28'd0, count}, 6);
    checkOutput("fill_refull_full", {31'd0, full}, 1);
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("fill_drain_valid", {31'd0, m_valid}, 1);
      checkOutput("fill_drain_data", {24'd0, m_data}, k);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fill_drain_empty", {31'd0, empty}, 1);
    checkOutput("fill_drain_count", {28'd0, count}, 0);

    // Streaming 0..99, one word per cycle after a 3-cycle fill
    for (int c = 0; c < 103; c++) begin
      applyStimulus(c < 100, 8'(c), 1'b1);
      if (c < 100) checkOutput("stream_ready", {31'd0, s_ready}, 1);
      if (c >= 3) begin
        checkOutput("stream_valid", {31'd0, m_valid}, 1);
        checkOutput("stream_data", {24'd0, m_data}, c - 3);
      end else begin
        checkOutput("stream_fill_valid", {31'd0, m_valid}, 0);
      end
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stream_empty", {31'd0, empty}, 1);

    // Backpressure with m_ready toggling 1,0,1,0
    sent = 0;
    held = 1'b0;
    prev = '0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(sent < 24, 8'(8'h40 + sent), (c % 2) == 0);
      if (held) checkOutput("bp_stable", {24'd0, m_data}, {24'd0, prev});
      held = m_valid && !m_ready;
      prev = m_data;
      if (s_valid && s_ready) sent++;
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    guard = 0;
    while (!empty && guard < 50) begin
      tick();
      guard++;
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("bp_drain_empty", {31'd0, empty}, 1);
    checkOutput("bp_sent", sent, 24);
    checkOutput("bp_sb_left", sbq.size(), 0);

    // Wrap: 20 fill/drain rounds walk the pointers around many times
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 6; k++) begin
        applyStimulus(1'b1, 8'(r * 6 + k), 1'b0);
        checkOutput("wrap_ready", {31'd0, s_ready}, 1);
        tick();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("wrap_full", {31'd0, full}, 1);
      checkOutput("wrap_full_count", {28'd0, count}, 6);
      checkOutput("wrap_full_ready", {31'd0, s_ready}, 0);
      for (int k = 0; k < 6; k++) begin
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("wrap_valid", {31'd0, m_valid}, 1);
        checkOutput("wrap_data", {24'd0, m_data}, r * 6 + k);
        tick();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("wrap_empty", {31'd0, empty}, 1);
      checkOutput("wrap_empty_count", {28'd0, count}, 0);
      checkOutput("wrap_empty_full", {31'd0, full}, 0);
    end

    // Reset mid-stream with 5 words held
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h50 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("midrst_pre_count", {28'd0, count}, 5);
    rstn = 1'b0;
    #1;
    checkResetState("midrst");
    tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    applyStimulus(1'b1, 8'hAA, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("midrst_valid", {31'd0, m_valid}, 1);
    checkOutput("midrst_data", {24'd0, m_data}, 32'hAA);
    checkOutput("midrst_count", {28'd0, count}, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midrst_end_empty", {31'd0, empty}, 1);
    checkOutput("midrst_end_valid", {31'd0, m_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
